// File: rtl/reset_request_gen.sv
// Merges POR, button, software and watchdog sources into one stretched rst_req.
// Watchdog is built only when RESET_REQ_WATCHDOG_EN is defined.
module reset_request_gen #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STRETCH_CYCLES  = 16,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n_in,
  input  logic       sw_rst_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       rst_req,
  output logic [1:0] rst_cause
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW =
    (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_MAX =
    SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_stretch;
  logic [SW-1:0]   w_stretch_nxt;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause_nxt;
  logic            r_rst_req;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_deb;
  logic            r_deb_d;
  logic [DW-1:0]   r_db_cnt;
  logic            w_btn_evt;
  logic            w_wdt_evt;
  logic            w_any_evt;

  // Button released (1) is the safe level while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_deb    <= 1'b1;
      r_deb_d  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_n_in;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 != r_deb) begin
        if (r_db_cnt == DB_MAX) begin
          r_deb    <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_btn_evt = r_deb_d & ~r_deb;

`ifdef RESET_REQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_MAX =
    WW'(WDT_CYCLES - 1);

  logic [WW-1:0] r_wdt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
    end else if (!wdt_en || wdt_kick ||
                 r_state != S_IDLE) begin
      r_wdt_cnt <= '0;
    end else if (r_wdt_cnt != WDT_MAX) begin
      r_wdt_cnt <= r_wdt_cnt + WW'(1);
    end
  end

  assign w_wdt_evt = wdt_en && !wdt_kick &&
                     (r_state == S_IDLE) &&
                     (r_wdt_cnt == WDT_MAX);
`else
  localparam int p_unused_wdt = WDT_CYCLES;
  logic w_unused_wdt;

  assign w_unused_wdt = wdt_en ^ wdt_kick;
  assign w_wdt_evt    = 1'b0;
`endif

  assign w_any_evt = w_btn_evt | w_wdt_evt | sw_rst_req;

  always_comb begin
    w_next        = r_state;
    w_stretch_nxt = r_stretch;
    w_cause_nxt   = r_cause;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_evt) begin
          w_next        = S_ASSERT;
          w_stretch_nxt = '0;
          if (w_btn_evt)      w_cause_nxt = 2'b01;
          else if (w_wdt_evt) w_cause_nxt = 2'b11;
          else                w_cause_nxt = 2'b10;
        end
      end
      S_ASSERT: begin
        if (r_stretch == ST_MAX) begin
          w_next = S_RELEASE_WAIT;
        end else begin
          w_stretch_nxt = r_stretch + SW'(1);
        end
      end
      S_RELEASE_WAIT: begin
        if (r_deb && !sw_rst_req) w_next = S_IDLE;
      end
      default: begin
        w_next        = S_ASSERT;
        w_stretch_nxt = '0;
      end
    endcase
  end

  // rst_req comes straight from a flop so it can never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_ASSERT;
      r_stretch <= '0;
      r_cause   <= 2'b00;
      r_rst_req <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_stretch <= w_stretch_nxt;
      r_cause   <= w_cause_nxt;
      r_rst_req <= (w_next != S_IDLE);
    end
  end

  assign rst_req   = r_rst_req;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_reset_request_gen.sv
// Randomised bench for reset_request_gen against a cycle-level behavioural model.
// Directed phases pin the model to hand-computed latencies.
module tb_reset_request_gen;

  localparam int D = 4;
  localparam int S = 8;
  localparam int W = 32;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       btn_n_in   = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_en     = 1'b0;
  logic       wdt_kick   = 1'b0;
  logic       rst_req;
  logic [1:0] rst_cause;

  int errors = 0;
  int checks = 0;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(D),
    .STRETCH_CYCLES (S),
    .WDT_CYCLES     (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n_in  (btn_n_in),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .rst_req   (rst_req),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: reset request as "remaining stretch time" plus a release rule
  bit         m_req    = 1'b1;
  int         m_left   = S;
  logic [1:0] m_cause  = 2'd0;
  bit         m_s1     = 1'b1;
  bit         m_s2     = 1'b1;
  bit         m_deb    = 1'b1;
  bit         m_deb_pv = 1'b1;
  int         m_run    = 0;
  int         m_wrun   = 0;
  bit         m_bev;
  bit         m_wev;
  bit         m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 1'b1; m_left = S; m_cause = 2'd0;
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_deb = 1'b1; m_deb_pv = 1'b1;
      m_run = 0; m_wrun = 0;
    end else begin
      m_bev  = m_deb_pv && !m_deb;
      m_wev  = 1'b0;
      m_idle = !m_req;
`ifdef RESET_REQ_WATCHDOG_EN
      m_wev = m_idle && wdt_en && !wdt_kick &&
              (m_wrun == W - 1);
`endif
      if (m_idle) begin
        if (m_bev || m_wev || sw_rst_req) begin
          m_req   = 1'b1;
          m_left  = S;
          m_cause = m_bev ? 2'd1 : (m_wev ? 2'd3 : 2'd2);
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_deb && !sw_rst_req) begin
        m_req = 1'b0;
      end
      if (m_idle && wdt_en && !wdt_kick)
        m_wrun = (m_wrun < W - 1) ? m_wrun + 1 : m_wrun;
      else
        m_wrun = 0;
      m_deb_pv = m_deb;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == D) begin
          m_deb = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n_in;
    end
  end

  always @(negedge clk) begin
    check("rst_req", int'(rst_req), int'(m_req));
    check("rst_cause", int'(rst_cause), int'(m_cause));
  end

  task automatic wait_level(input logic lvl,
                            input int budget,
                            output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rst_req !== lvl && n <= budget);
  endtask

  task automatic quiet_highs(input int cyc, output int hi);
    hi = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (rst_req) hi++;
    end
  endtask

  task automatic pulse_sw;
    @(posedge clk); #1; sw_rst_req = 1'b1;
    @(posedge clk); #1; sw_rst_req = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    int first;
    int hold;

    repeat (3) @(posedge clk);
    #1;
    check("por_req", int'(rst_req), 1);
    check("por_cause", int'(rst_cause), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_level(1'b0, 30, n);
    check("por_fall", n, 9);
    quiet_highs(5, hi);

    // short glitch must be rejected
    @(posedge clk); #1; btn_n_in = 1'b0;
    repeat (3) @(posedge clk);
    #1; btn_n_in = 1'b1;
    quiet_highs(15, hi);
    check("glitch_no_reset", hi, 0);

    btn_n_in = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (rst_req && first == 0) first = i;
      if (i == 10) btn_n_in = 1'b1;
    end
    check("btn_rise", first, 7);
    check("btn_cause", int'(rst_cause), 1);
    wait_level(1'b0, 60, n);
    check("btn_fall_bound", int'(n <= 60), 1);
    quiet_highs(30, hi);
    check("btn_no_retrig", hi, 0);

    btn_n_in = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 40) begin
        check("held_req", int'(rst_req), 1);
        btn_n_in = 1'b1;
      end
    end
    wait_level(1'b0, 40, n);
    check("held_fall", n, 7);
    quiet_highs(30, hi);
    check("held_no_retrig", hi, 0);

    pulse_sw();
    n = rst_req ? 1 : 0;
    for (int i = 0; i < 40 && rst_req; i++) begin
      @(posedge clk); #1;
      if (rst_req) n++;
    end
    check("sw_high_len", n, 9);
    check("sw_cause", int'(rst_cause), 2);
    quiet_highs(5, hi);

    btn_n_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 6) sw_rst_req = 1'b1;
      if (i == 7) begin
        sw_rst_req = 1'b0;
        check("tie_rise", int'(rst_req), 1);
      end
      if (i == 10) btn_n_in = 1'b1;
    end
    check("tie_cause", int'(rst_cause), 1);
    wait_level(1'b0, 60, n);
    quiet_highs(5, hi);

`ifdef RESET_REQ_WATCHDOG_EN
    wdt_en = 1'b1;
    wait_level(1'b1, 60, n);
    check("wdt_rise", n, 32);
    check("wdt_cause", int'(rst_cause), 3);
    wdt_en = 1'b0;
    wait_level(1'b0, 40, n);
    wdt_en = 1'b1;
    hi = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      wdt_kick = (i % 20 == 0);
      if (rst_req) hi++;
    end
    wdt_kick = 1'b0;
    wdt_en   = 1'b0;
    check("wdt_kicked", hi, 0);
`else
    wdt_en = 1'b1;
    quiet_highs(60, hi);
    wdt_en = 1'b0;
    check("wdt_absent", hi, 0);
`endif
    quiet_highs(3, hi);

    pulse_sw();
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_cause", int'(rst_cause), 2);
    rst_n = 1'b0;
    #1;
    check("abort_req", int'(rst_req), 1);
    check("abort_cause", int'(rst_cause), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wait_level(1'b0, 30, n);
    check("abort_por_fall", n, 9);

    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (hold == 0) begin
        btn_n_in = ($urandom_range(0, 2) != 0);
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      sw_rst_req = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) wdt_en = ~wdt_en;
      wdt_kick = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 699) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    btn_n_in = 1'b1;
    sw_rst_req = 1'b0;
    wdt_kick = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
